// File: rtl/fl_pkg.sv
// Shared types, sizes and helpers for the FL layer scheduler.
// Optional feature macro: ARGMAX_EN (enables the winning-class scan).
package fl_pkg;

    localparam int DATA_W      = 16;  // Q8.8 signed FL output width
    localparam int NUM_CLASSES = 10;  // FL0..FL9
    localparam int CLASS_W     = 4;   // width of a class index
    localparam int BLK_W       = 7;   // block count / block index width
    localparam int NUM_W       = 7;   // FL input-count width
    localparam int MAX_GAP     = 1;   // idle cycles between blocks (>=1)
    localparam int GAP_W       = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        GAP,
        SCAN,
        RESULT
    } fl_state_e;

    // Pick accumulator idx out of the packed FL output bus (FL0 in the LSBs).
    function automatic logic [DATA_W-1:0] fl_slice(
        input logic [NUM_CLASSES*DATA_W-1:0] bus,
        input logic [CLASS_W-1:0]            idx
    );
        return bus[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/fl_argmax.sv
// Sequential argmax over the ten FL accumulators, one class per cycle.
// A start pulse arms the scan; the cycle with idx==0 loads FL0 as the first
// best, later cycles replace it only on a strictly greater signed value, so
// ties keep the lowest index. done is high during the last scan cycle; the
// best/bidx registers then hold until the next start.
module fl_argmax
    import fl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_CLASSES*DATA_W-1:0] fl_out,
    output logic                          done,
    output logic [CLASS_W-1:0]            best_idx,
    output logic [DATA_W-1:0]             best_val
);

    logic               active_q;
    logic [CLASS_W-1:0] idx_q;
    logic [DATA_W-1:0]  cur;

    assign cur  = fl_slice(fl_out, idx_q);
    assign done = active_q && (idx_q == CLASS_W'(NUM_CLASSES - 1));

    // Scan counter and running maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            best_idx <= '0;
            best_val <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            idx_q    <= '0;
        end else if (active_q) begin
            if ((idx_q == '0) || ($signed(cur) > $signed(best_val))) begin
                best_val <= cur;
                best_idx <= idx_q;
            end
            if (done) begin
                active_q <= 1'b0;
            end else begin
                idx_q <= idx_q + CLASS_W'(1);
            end
        end
    end

endmodule

// File: rtl/fl_scheduler.sv
// Fully-connected-layer pass sequencer: clear FL, run it once per weight
// block, optionally scan for the winning class, and hand back the result.
// Optional feature macro: ARGMAX_EN. Without it the scan is skipped and the
// result is class 0 with FL0's value.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// cmd_ready is high only in IDLE; cmd_valid offered elsewhere is dropped,
// not queued. res_valid is high only in RESULT and res_class/res_score are
// held constant until the cycle in which res_ready is also high.
module fl_scheduler
    import fl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [NUM_W-1:0]              cmd_num,
    input  logic [BLK_W-1:0]              cmd_blocks,
    output logic                          fl_clr,
    output logic                          fl_start,
    output logic [NUM_W-1:0]              fl_num,
    output logic [BLK_W-1:0]              fl_num_block,
    input  logic                          fl_done,
    input  logic [NUM_CLASSES*DATA_W-1:0] fl_out,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [CLASS_W-1:0]            res_class,
    output logic [DATA_W-1:0]             res_score,
    output logic                          busy
);

    fl_state_e          state_q, state_d;
    logic [BLK_W-1:0]   blk_q;
    logic [BLK_W-1:0]   blocks_q;
    logic [NUM_W-1:0]   num_q;
    logic [GAP_W-1:0]   gap_q;
    logic               run_first_q;
    logic               last_blk;
    logic               gap_end;
    logic               scan_start;

    assign last_blk     = (blk_q == blocks_q - BLK_W'(1));
    assign gap_end      = (gap_q == GAP_W'(MAX_GAP - 1));
    assign scan_start   = (state_q == GAP) && gap_end && last_blk;
    assign fl_num       = num_q;
    assign fl_num_block = blk_q;
    assign busy         = (state_q != IDLE);

`ifdef ARGMAX_EN
    logic scan_done;

    fl_argmax u_argmax (
        .clk      (clk),
        .rst      (rst),
        .start    (scan_start),
        .fl_out   (fl_out),
        .done     (scan_done),
        .best_idx (res_class),
        .best_val (res_score)
    );
`else
    logic [DATA_W-1:0] fl0_q;
    logic              unused_fl_out;

    // Only FL0 is reported when the scan is not built.
    assign unused_fl_out = ^fl_out[NUM_CLASSES*DATA_W-1:DATA_W];
    assign res_class     = '0;
    assign res_score     = fl0_q;

    // Capture FL0 as the last block finishes so the result stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            fl0_q <= '0;
        end else if (scan_start) begin
            fl0_q <= fl_out[DATA_W-1:0];
        end
    end
`endif

    // State register plus command latch, block counter and gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            blocks_q    <= BLK_W'(1);
            num_q       <= '0;
            gap_q       <= '0;
            run_first_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            // High in the first RUN cycle so a stale fl_done level is ignored.
            run_first_q <= (state_q != RUN);
            if ((state_q == IDLE) && cmd_valid) begin
                num_q    <= cmd_num;
                blocks_q <= (cmd_blocks == '0) ? BLK_W'(1) : cmd_blocks;
                blk_q    <= '0;
            end
            if (state_q == RUN) begin
                gap_q <= '0;
            end else if (state_q == GAP) begin
                gap_q <= gap_q + GAP_W'(1);
            end
            if ((state_q == GAP) && gap_end && !last_blk) begin
                blk_q <= blk_q + BLK_W'(1);
            end
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        fl_clr    = 1'b0;
        fl_start  = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = CLEAR;
            end
            CLEAR: begin
                fl_clr  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                fl_start = 1'b1;
                if (fl_done && !run_first_q) state_d = GAP;
            end
            GAP: begin
                if (gap_end) begin
                    if (last_blk) begin
`ifdef ARGMAX_EN
                        state_d = SCAN;
`else
                        state_d = RESULT;
`endif
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            SCAN: begin
`ifdef ARGMAX_EN
                if (scan_done) state_d = RESULT;
`else
                state_d = RESULT;
`endif
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fl_scheduler.sv
// Self-checking bench for fl_scheduler with a behavioural FL model:
// done rises run_len cycles after fl_start goes high and drops once
// fl_start is low (optionally one cycle late to exercise the stale level).
module tb_fl_scheduler;
    import fl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- DUT ----------------
    logic                          cmd_valid = 1'b0;
    logic                          cmd_ready;
    logic [NUM_W-1:0]              cmd_num = '0;
    logic [BLK_W-1:0]              cmd_blocks = '0;
    logic                          fl_clr;
    logic                          fl_start;
    logic [NUM_W-1:0]              fl_num;
    logic [BLK_W-1:0]              fl_num_block;
    logic                          fl_done;
    logic [NUM_CLASSES*DATA_W-1:0] fl_out = '0;
    logic                          res_valid;
    logic                          res_ready = 1'b0;
    logic [CLASS_W-1:0]            res_class;
    logic [DATA_W-1:0]             res_score;
    logic                          busy;

    fl_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_num      (cmd_num),
        .cmd_blocks   (cmd_blocks),
        .fl_clr       (fl_clr),
        .fl_start     (fl_start),
        .fl_num       (fl_num),
        .fl_num_block (fl_num_block),
        .fl_done      (fl_done),
        .fl_out       (fl_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_class    (res_class),
        .res_score    (res_score),
        .busy         (busy)
    );

    // ---------------- FL model ----------------
    int   run_len    = 1;
    bit   stale_mode = 1'b0;
    int   fl_cnt     = 0;
    logic done_r     = 1'b0;
    logic done_d     = 1'b0;

    always @(posedge clk) begin
        if (!fl_start) begin
            fl_cnt <= 0;
            done_r <= 1'b0;
        end else begin
            fl_cnt <= fl_cnt + 1;
            done_r <= (fl_cnt + 1 >= run_len);
        end
        done_d <= done_r;
    end
    assign fl_done = done_r | (stale_mode & done_d);

    // ---------------- consumer ----------------
    int hold_until = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            res_ready = (cyc < hold_until) ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- scoreboard state ----------------
    // {expected first res_valid cycle[51:20], class[19:16], score[15:0]}
    logic [51:0]       exp_q[$];
    logic [DATA_W-1:0] fl_vals[NUM_CLASSES];
    int checks       = 0;
    int errors       = 0;
    int issued       = 0;
    int results_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: winning class by strict signed greater-than, lowest index on ties.
    function automatic logic [19:0] ref_result();
`ifdef ARGMAX_EN
        int bi = 0;
        for (int i = 1; i < NUM_CLASSES; i++)
            if ($signed(fl_vals[i]) > $signed(fl_vals[bi])) bi = i;
        return {CLASS_W'(bi), fl_vals[bi]};
`else
        return {CLASS_W'(0), fl_vals[0]};
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [NUM_W-1:0] num, input logic [BLK_W-1:0] blocks,
                            input int n_run, input bit stale, input int hold);
        int b;
        int lat;
        int waited;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CLASSES; i++) fl_out[i*DATA_W +: DATA_W] = fl_vals[i];
        run_len    = n_run;
        stale_mode = stale;
        cmd_num    = num;
        cmd_blocks = blocks;
        cmd_valid  = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready %0b required 1", cmd_ready);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            return;
        end
        b   = (blocks == '0) ? 1 : int'(blocks);
        lat = 2 + b * (n_run + 1) + b * MAX_GAP;
`ifdef ARGMAX_EN
        lat = lat + NUM_CLASSES;
`endif
        exp_q.push_back({32'(cyc + lat), ref_result()});
        if (hold > 0) hold_until = cyc + lat + hold;
        issued++;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_results();
        int w = 0;
        while (results_done != issued && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (results_done != issued) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: results %0d required %0d", results_done, issued);
        end
        @(negedge clk);
        check("idle_after_result", {30'd0, busy, cmd_ready}, 32'd1);
    endtask

    task automatic wait_run(input logic [BLK_W-1:0] blk);
        int w = 0;
        @(negedge clk);
        while (!(fl_start && fl_num_block == blk) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!(fl_start && fl_num_block == blk)) begin
            checks++;
            errors++;
            $display("FAIL run_wait_timeout: block %0d never ran (fl_num_block %0d)", blk, fl_num_block);
        end
    endtask

    task automatic rand_vals(input int lo, input int hi);
        for (int i = 0; i < NUM_CLASSES; i++) fl_vals[i] = DATA_W'($urandom_range(lo, hi));
    endtask

    // ---------------- monitor ----------------
    bit          seen       = 1'b0;
    bit          prev_start = 1'b0;
    int          clr_cnt    = 0;
    int          run_cnt    = 0;
    int          cur_blocks = 1;
    logic [NUM_W-1:0] cur_num = '0;
    logic [51:0] cur_exp    = '0;

    always @(negedge clk) begin
        if (rst) begin
            seen       = 1'b0;
            prev_start = 1'b0;
            clr_cnt    = 0;
            run_cnt    = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                clr_cnt    = 0;
                run_cnt    = 0;
                cur_num    = cmd_num;
                cur_blocks = (cmd_blocks == '0) ? 1 : int'(cmd_blocks);
            end
            if (fl_clr) clr_cnt++;
            if (fl_start && !prev_start) begin
                check("fl_num_block_step", 32'(fl_num_block), 32'(run_cnt));
                check("fl_num_latched", 32'(fl_num), 32'(cur_num));
                run_cnt++;
            end
            prev_start = fl_start;
            if (res_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: class %0d score %0h, none required", res_class, res_score);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        check("result_latency_cycle", 32'(cyc), cur_exp[51:20]);
                        check("res_class", 32'(res_class), 32'(cur_exp[19:16]));
                        check("res_score", 32'(res_score), 32'(cur_exp[15:0]));
                        check("clr_pulses", 32'(clr_cnt), 32'd1);
                        check("run_phases", 32'(run_cnt), 32'(cur_blocks));
                    end
                    seen = 1'b1;
                end else begin
                    check("res_stable", {12'd0, res_class, res_score}, {12'd0, cur_exp[19:0]});
                end
                if (res_ready) begin
                    seen = 1'b0;
                    results_done++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_fl_ctrl", {30'd0, fl_clr, fl_start}, 32'd0);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_fl_num_block", 32'(fl_num_block), 32'd0);
        check("reset_fl_num", 32'(fl_num), 32'd0);
        check("reset_result", {12'd0, res_class, res_score}, 32'd0);

        // Single block, FL9 clearly largest.
        rand_vals(0, 16'h0100);
        fl_vals[9] = 16'h0300;
        send_cmd(7'd5, 7'd1, 3, 1'b0, 0);
        wait_results();

        // Three blocks with stale done levels at each RUN entry.
        rand_vals(0, 16'hFFFF);
        send_cmd(7'd17, 7'd3, 2, 1'b1, 0);
        wait_results();

        // Tie between FL2 and FL6.
        rand_vals(0, 16'h01FF);
        fl_vals[2] = 16'h0200;
        fl_vals[6] = 16'h0200;
        send_cmd(7'd9, 7'd2, 1, 1'b0, 0);
        wait_results();

        // All negative, FL4 the largest.
        rand_vals(16'h8000, 16'hFF7F);
        fl_vals[4] = 16'hFF80;
        send_cmd(7'd3, 7'd1, 4, 1'b0, 0);
        wait_results();

        // Consumer stalls 20 cycles; a command pulse during RUN is dropped.
        rand_vals(0, 16'hFFFF);
        send_cmd(7'd42, 7'd2, 3, 1'b0, 20);
        wait_run(7'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_num   = 7'd99;
        @(negedge clk);
        check("cmd_ready_in_run", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_results();

        // Reset during block 1 aborts immediately.
        rand_vals(0, 16'hFFFF);
        send_cmd(7'd11, 7'd3, 3, 1'b0, 0);
        wait_run(7'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_fl_start", 32'(fl_start), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        void'(exp_q.pop_back());
        issued--;
        rand_vals(0, 16'hFFFF);
        send_cmd(7'd12, 7'd2, 2, 1'b0, 0);
        wait_results();

        // Zero blocks behaves as one block.
        rand_vals(0, 16'hFFFF);
        send_cmd(7'd1, 7'd0, 2, 1'b1, 0);
        wait_results();

        // Randomized commands, with occasional forced ties.
        for (int t = 0; t < 14; t++) begin
            rand_vals(0, 16'hFFFF);
            if ($urandom_range(0, 2) == 0)
                fl_vals[$urandom_range(0, NUM_CLASSES - 1)] = fl_vals[$urandom_range(0, NUM_CLASSES - 1)];
            send_cmd(NUM_W'($urandom_range(0, 127)), BLK_W'($urandom_range(0, 5)),
                     $urandom_range(1, 6), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
            wait_results();
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
